// File: rtl/dumbrv_spi_sram_if.sv
// SPI pin bundle between the dumbrv SPI master and the serial-SRAM responder.
// Latency: none, wires only. Backpressure: none, the master owns SCK pacing.
// Signals: sck (idles low), mosi and miso (MSB first), cs (active-high select).
interface dumbrv_spi_sram_if;
  logic sck;
  logic mosi;
  logic cs;
  logic miso;

  modport master (output sck, output mosi, output cs, input miso);
  modport slave  (input sck, input mosi, input cs, output miso);
endinterface

// File: rtl/dumbrv_spi_sram.sv
// 23LC-style serial SRAM responder: READ 0x03 / WRITE 0x02, 16-bit address, sequential bytes.
// Latency: read data is loaded one clk after the completing SCK rise; +2 clk input latency when synced.
// Backpressure: none; the master paces every bit with SCK and a cs low aborts any transaction.
// Ports: clk, rst (sync, active-high); spi (slave modport: sck/mosi/cs in, miso out);
//   bk_we/bk_addr/bk_wdata backdoor write, bk_rdata combinational backdoor read;
//   active_o high during a decoded data phase; err_o high after an unknown command until cs low.
// Build option: define DUMBRV_SPI_SYNC_EN to pass sck/mosi/cs through 2-flop synchronizers
//   (asynchronous masters, clk >= 8x SCK). Undefined: pins are used directly on clk.
module dumbrv_spi_sram #(
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  dumbrv_spi_sram_if.slave        spi,
  input  logic                    bk_we,
  input  logic [ADDR_W-1:0]       bk_addr,
  input  logic [7:0]              bk_wdata,
  output logic [7:0]              bk_rdata,
  output logic                    active_o,
  output logic                    err_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {S_CMD, S_ADR1, S_ADR2, S_READ, S_WRITE, S_IGNORE} state_t;

  logic sck_i, mosi_i, cs_i;

`ifdef DUMBRV_SPI_SYNC_EN
  logic [1:0] sck_sync, mosi_sync, cs_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
    end else begin
      sck_sync  <= {sck_sync[0], spi.sck};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      cs_sync   <= {cs_sync[0], spi.cs};
    end
  end

  assign sck_i  = sck_sync[1];
  assign mosi_i = mosi_sync[1];
  assign cs_i   = cs_sync[1];
`else
  assign sck_i  = spi.sck;
  assign mosi_i = spi.mosi;
  assign cs_i   = spi.cs;
`endif

  state_t      state, state_nxt;
  logic        sck_q;
  logic [2:0]  bitcnt;
  logic [6:0]  rx;
  logic [7:0]  tx;
  logic [15:0] addr;
  logic        is_rd;
  logic        load_pend;
  logic [7:0]  mem [DEPTH];

  logic              rise;
  logic              byte_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] mem_idx;
  logic              spi_we;

  assign rise      = sck_i & ~sck_q;
  assign byte_done = cs_i & rise & (bitcnt == 3'd7);
  assign rx_byte   = {rx, mosi_i};
  // Upper address bits beyond the array size are carried but never index.
  assign mem_idx   = ADDR_W'(addr);
  assign spi_we    = ~rst & byte_done & (state == S_WRITE);

  // miso is the live MSB of tx: valid before the master's rising-edge sample,
  // advanced by the shift on that same rise.
  assign spi.miso  = tx[7];
  assign bk_rdata  = mem[bk_addr];

  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!cs_i) begin
      state_nxt = S_CMD;
    end else if (byte_done) begin
      case (state)
        S_CMD:   state_nxt = (rx_byte == 8'h03 || rx_byte == 8'h02) ? S_ADR1 : S_IGNORE;
        S_ADR1:  state_nxt = S_ADR2;
        S_ADR2:  state_nxt = is_rd ? S_READ : S_WRITE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q     <= 1'b0;
      bitcnt    <= 3'd0;
      rx        <= '0;
      tx        <= '0;
      addr      <= '0;
      is_rd     <= 1'b0;
      load_pend <= 1'b0;
      active_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      sck_q <= sck_i;
      if (!cs_i) begin
        bitcnt    <= 3'd0;
        rx        <= '0;
        tx        <= '0;
        load_pend <= 1'b0;
        active_o  <= 1'b0;
        err_o     <= 1'b0;
      end else begin
        load_pend <= 1'b0;
        if (rise) begin
          rx     <= rx_byte[6:0];
          bitcnt <= bitcnt + 3'd1;
          tx     <= {tx[6:0], 1'b0};
          if (byte_done) begin
            case (state)
              S_CMD: begin
                is_rd <= (rx_byte == 8'h03);
                err_o <= (rx_byte != 8'h03) && (rx_byte != 8'h02);
              end
              S_ADR1: addr[15:8] <= rx_byte;
              S_ADR2: begin
                addr[7:0] <= rx_byte;
                active_o  <= 1'b1;
                load_pend <= is_rd;
              end
              S_READ: begin
                addr      <= addr + 16'd1;
                load_pend <= 1'b1;
              end
              S_WRITE: addr <= addr + 16'd1;
              default: ;
            endcase
          end
        end
        // Read data is fetched one clk after the byte completes, using the
        // address already updated on that completion edge.
        if (load_pend) tx <= mem[mem_idx];
      end
    end
  end

  // Array is never reset. SPI write is ordered last so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (bk_we)  mem[bk_addr] <= bk_wdata;
    if (spi_we) mem[mem_idx] <= rx_byte;
  end
endmodule
